// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Front end between the board switches/keys and the game control FSM. Six raw,
// asynchronous, bouncy active-high button levels are synchronized, debounced
// and turned into registered single-cycle command pulses, so that one physical
// press gives exactly one cursor move or one selection.
//
// Optional build macro: INPUT_AUTOREPEAT_EN
//   When defined, a direction that stays pressed re-pulses REPEAT_DELAY cycles
//   after its initial pulse and then every REPEAT_PERIOD cycles. When it is
//   undefined, each press produces exactly one pulse.
//
// Ports
//   clk           system clock (CLOCK_50)
//   resetn        asynchronous active-low reset
//   up_raw .. deselect_raw
//                 raw active-high button levels (asynchronous)
//   enable        synchronous; when low every pulse output is forced to 0,
//                 debouncing and held keep running
//   up, down, left, right
//                 one-cycle direction pulses, mutually exclusive,
//                 priority up > down > left > right
//   select, deselect
//                 one-cycle action pulses, select wins a tie
//   held[5:0]     debounced levels {deselect, select, right, left, down, up}
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       left_raw,
  input  logic       right_raw,
  input  logic       select_raw,
  input  logic       deselect_raw,
  input  logic       enable,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       select,
  output logic       deselect,
  output logic [5:0] held
);

  localparam int NCH = 6;
  // Last counter value before a pending level change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel order matches held: {deselect, select, right, left, down, up}.
  logic [NCH-1:0]   raw_s;
  logic [NCH-1:0]   s1_q, s1_d;
  logic [NCH-1:0]   s2_q, s2_d;
  logic [NCH-1:0]   st_q, st_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   rise_s;
  logic [3:0]       dir_req_s;
  logic [1:0]       act_req_s;
  logic [NCH-1:0]   win_s;
  logic [NCH-1:0]   pulse_q, pulse_d;

  assign raw_s = {deselect_raw, select_raw, right_raw, left_raw, down_raw, up_raw};

  // Two-flop synchronizer input selection.
  always_comb begin
    s1_d = raw_s;
    s2_d = s1_q;
  end

  // Per-channel debounce: a level change is accepted only after the
  // synchronized input has disagreed with the stable level for
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == st_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        st_d[i]  = s2_q[i];
        cnt_d[i] = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // A channel qualifies on the edge where its stable level goes 0->1.
  assign rise_s    = ~st_q & st_d;
  assign act_req_s = rise_s[5:4];

`ifdef INPUT_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q [4];
  logic [RPT_W-1:0] rpt_cnt_d [4];
  logic [3:0]       rpt_act_q, rpt_act_d;
  logic [3:0]       rpt_per_q, rpt_per_d;
  logic [3:0]       rpt_fire_s;

  // Repeat timers: armed by the rising qualification, first fire after
  // REPEAT_DELAY edges, then every REPEAT_PERIOD edges. Cleared as soon as
  // the stable level drops, so no repeat can fire on the release edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rpt_cnt_d[i]  = rpt_cnt_q[i];
      rpt_act_d[i]  = rpt_act_q[i];
      rpt_per_d[i]  = rpt_per_q[i];
      rpt_fire_s[i] = 1'b0;
      if (!st_d[i]) begin
        rpt_cnt_d[i] = {RPT_W{1'b0}};
        rpt_act_d[i] = 1'b0;
        rpt_per_d[i] = 1'b0;
      end else if (rise_s[i]) begin
        rpt_cnt_d[i] = {RPT_W{1'b0}};
        rpt_act_d[i] = 1'b1;
        rpt_per_d[i] = 1'b0;
      end else if (rpt_act_q[i]) begin
        if (rpt_cnt_q[i] == (rpt_per_q[i] ? RPT_PER_LAST : RPT_DLY_LAST)) begin
          rpt_fire_s[i] = 1'b1;
          rpt_cnt_d[i]  = {RPT_W{1'b0}};
          rpt_per_d[i]  = 1'b1;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + {{(RPT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i];
      end
    end
  end

  // Repeat timer state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        rpt_cnt_q[i] <= {RPT_W{1'b0}};
      end
      rpt_act_q <= 4'b0000;
      rpt_per_q <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
      rpt_act_q <= rpt_act_d;
      rpt_per_q <= rpt_per_d;
    end
  end

  assign dir_req_s = rise_s[3:0] | rpt_fire_s;
`else
  // Repeat parameters have no function in the single-pulse build.
  logic unused_rpt_s;
  assign unused_rpt_s = (REPEAT_DELAY != 32'sd0) ^ (REPEAT_PERIOD != 32'sd0);
  assign dir_req_s    = rise_s[3:0];
`endif

  // Arbitration and enable gating. Losing requests are dropped, not deferred;
  // directions and actions are arbitrated independently.
  always_comb begin
    win_s = 6'b000000;
    if (dir_req_s[0]) begin
      win_s[0] = 1'b1;
    end else if (dir_req_s[1]) begin
      win_s[1] = 1'b1;
    end else if (dir_req_s[2]) begin
      win_s[2] = 1'b1;
    end else if (dir_req_s[3]) begin
      win_s[3] = 1'b1;
    end else begin
      win_s[3:0] = 4'b0000;
    end
    if (act_req_s[0]) begin
      win_s[4] = 1'b1;
    end else if (act_req_s[1]) begin
      win_s[5] = 1'b1;
    end else begin
      win_s[5:4] = 2'b00;
    end
    if (enable) begin
      pulse_d = win_s;
    end else begin
      pulse_d = 6'b000000;
    end
  end

  // Synchronizers, debounce state and pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q    <= 6'b000000;
      s2_q    <= 6'b000000;
      st_q    <= 6'b000000;
      pulse_q <= 6'b000000;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      st_q    <= st_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign up       = pulse_q[0];
  assign down     = pulse_q[1];
  assign left     = pulse_q[2];
  assign right    = pulse_q[3];
  assign select   = pulse_q[4];
  assign deselect = pulse_q[5];
  assign held     = st_q;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage between board switches/keys and the game `control` FSM.
- Converts six raw, asynchronous, bouncy active-high button levels into synchronized, debounced, single-cycle command pulses:
  - directions: up / down / left / right
  - actions: select / deselect
- `control` consumes the pulses directly, so one physical press yields exactly one cursor move or selection.
- Top level drives `*_raw` from `SW[1]`, `SW[2]`, `SW[3]`, `SW[0]`, `~KEY[0]` and `~KEY[1]`.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); must be >= 2.
- CNT_W, 20, width of each debounce counter; requires 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 25000000, cycles from the initial pulse to the first auto-repeat pulse. Used only under the optional feature.
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses. Used only under the optional feature.

Ports:
- clk  input  1  system clock (CLOCK_50).
- resetn  input  1  asynchronous, active-low reset.
- up_raw, down_raw, left_raw, right_raw  input  1 each  raw direction levels, active-high, asynchronous.
- select_raw, deselect_raw  input  1 each  raw action levels, active-high, asynchronous.
- enable  input  1  synchronous. When low, all pulse outputs are forced to 0; debouncing continues.
- up, down, left, right  output  1 each  registered one-cycle direction pulses.
- select, deselect  output  1 each  registered one-cycle action pulses.
- held  output  6  debounced levels {deselect, select, right, left, down, up}, registered.

Behaviour:
- Reset:
  - Asynchronous clear of all synchronizer flops, counters, stable levels, `held`, every pulse output and the repeat timers.
  - All outputs read 0 during reset and on the first edge after release.
- Synchronization:
  - Each raw input passes through two flops, s1 then s2.
  - No raw signal is used anywhere else.
- Debounce, per channel:
  - Keep a stable level `st` and a counter `cnt`.
  - On each edge where s2 == st: cnt <= 0.
  - On each edge where s2 != st and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - On each edge where s2 != st and cnt == DEBOUNCE_CYCLES-1: st <= s2 and cnt <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles restarts the count and is never accepted.
- Pulse generation:
  - A channel "qualifies" on the edge where its st changes 0->1.
  - The pulse register is set on that same edge and cleared on the next edge, so it is high for exactly one cycle.
  - Latency: the pulse is high in the cycle after edge E(N+2), where E1 is the first edge sampling raw=1 and N = DEBOUNCE_CYCLES.
  - A 1->0 change of st produces no pulse; it only updates `held`.
- Arbitration:
  - Direction pulses are mutually exclusive. If several directions qualify on the same edge, only the highest priority one pulses, with priority up > down > left > right.
  - Losing qualifications are discarded, not deferred.
  - If select and deselect qualify on the same edge, only select pulses.
  - Directions and actions are independent of each other and may pulse in the same cycle.
- Enable:
  - Pulses that qualify while enable=0 are discarded, not queued.
  - `held` is unaffected by enable.
- Boundaries:
  - Button held across reset release: stable restarts at 0, so one pulse is emitted N+2 edges after release.
  - Reset asserted mid-count: the count is lost.
  - Counter saturation is impossible because the counter is cleared whenever the stable value is reached.

Optional Feature:
- Macro INPUT_AUTOREPEAT_EN.
- When defined, each direction channel has a repeat timer, started on its initial pulse:
  - While st stays 1, additional pulses are emitted REPEAT_DELAY cycles after the initial pulse.
  - After that, pulses repeat every REPEAT_PERIOD cycles.
  - Repeat pulses obey direction priority and enable in the same way as initial pulses.
  - The timer is cleared when st returns to 0.
  - select and deselect never repeat.
- When not defined, the timers and parameters are unused and there is exactly one pulse per press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- up_raw 0->1 sampled first at edge E1 and held -> `up` high only in the cycle after E6; `held[0]`=1 from E6. up_raw released -> no pulse, `held[0]` clears 6 edges later.
- select_raw toggles 1,0,1,0 every 2 cycles for 12 cycles, then settles at 0 -> no `select` pulse, `held[4]` stays 0.
- left_raw and down_raw rise on the same cycle -> only `down` pulses (one cycle). select_raw and deselect_raw together -> only `select` pulses.
- enable=0 while right_raw is pressed -> no pulse and `held[3]`=1. enable raised while still held -> no late pulse.
- resetn pulsed low for 2 cycles, asynchronously and mid-debounce -> outputs 0 immediately. A button held through reset -> one pulse 6 edges after release.
- With INPUT_AUTOREPEAT_EN, hold up for 60 cycles after its first pulse -> pulses at +0, +20, +28, +36, +44, +52. Without the macro -> single pulse only.
